// File: rtl/pe_work_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : pe_work_dispatcher
// Description : Accepts frontier vertices one at a time. Each vertex goes to
//               one processing-element queue, chosen by round robin. PEs at or
//               below the load threshold are preferred. If none qualify, the
//               dispatcher falls back to any PE that is not full.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_work_dispatcher #(
  parameter int NUM_PE            = 4,
  parameter int QUEUE_DEPTH_WIDTH = 8,
  parameter int PE_INDEX_WIDTH    = 2,
  parameter int VERTEX_WIDTH      = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  enable,
  input  logic                                  in_valid,
  input  logic [VERTEX_WIDTH-1:0]               in_vertex,
  output logic                                  in_ready,
  input  logic [NUM_PE*QUEUE_DEPTH_WIDTH-1:0]   pe_queue_depths,
  input  logic [QUEUE_DEPTH_WIDTH-1:0]          dynamic_threshold,
  input  logic [NUM_PE-1:0]                     pe_full,
  output logic [NUM_PE-1:0]                     pe_push,
  output logic [VERTEX_WIDTH-1:0]               pe_vertex,
  output logic                                  busy,
  output logic [31:0]                           dispatch_count,
  output logic [31:0]                           stall_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_PUSH = 2'd2
  } state_t;

  localparam logic [PE_INDEX_WIDTH-1:0] LAST_PE = PE_INDEX_WIDTH'(NUM_PE - 1);

  state_t                    state_q, state_d;
  logic [VERTEX_WIDTH-1:0]   hold_vertex_q, hold_vertex_d;
  logic [PE_INDEX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [PE_INDEX_WIDTH-1:0] grant_q, grant_d;
  logic [31:0]               dispatch_count_q, dispatch_count_d;
  logic [31:0]               stall_count_q, stall_count_d;

  logic [NUM_PE-1:0]         preferred;
  logic [NUM_PE-1:0]         candidates;
  logic [PE_INDEX_WIDTH-1:0] arb_idx;
  logic [PE_INDEX_WIDTH-1:0] arb_grant;
  logic                      arb_found;
  logic                      push_ok;
  logic [PE_INDEX_WIDTH-1:0] rr_after_grant;

  // A PE is preferred when it can take a push and its queue is at or below the threshold
  generate
    for (genvar i = 0; i < NUM_PE; i++) begin : g_pref
      logic [QUEUE_DEPTH_WIDTH-1:0] depth;
      assign depth        = pe_queue_depths[i*QUEUE_DEPTH_WIDTH +: QUEUE_DEPTH_WIDTH];
      assign preferred[i] = !pe_full[i] && (depth <= dynamic_threshold);
    end
  endgenerate

  // Use the preferred set if it has any member; otherwise use every non-full PE
  always_comb begin
    candidates = (|preferred) ? preferred : ~pe_full;
  end

  // Round-robin search for the first candidate, starting at rr_ptr and wrapping
  always_comb begin
    arb_grant = '0;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int off = 0; off < NUM_PE; off++) begin
      arb_idx = PE_INDEX_WIDTH'((int'(rr_ptr_q) + off) % NUM_PE);
      if (!arb_found && candidates[arb_idx]) begin
        arb_grant = arb_idx;
        arb_found = 1'b1;
      end
    end
  end

  // The push needs the granted PE to still have room in the PUSH cycle itself
  always_comb begin
    push_ok        = (state_q == ST_PUSH) && !pe_full[grant_q];
    rr_after_grant = (grant_q == LAST_PE) ? '0 : grant_q + 1'b1;
    pe_push        = '0;
    if (push_ok) begin
      pe_push[grant_q] = 1'b1;
    end
  end

  // Next-state and datapath updates for the IDLE -> ARB -> PUSH sequence
  always_comb begin
    state_d          = state_q;
    hold_vertex_d    = hold_vertex_q;
    rr_ptr_d         = rr_ptr_q;
    grant_d          = grant_q;
    dispatch_count_d = dispatch_count_q;
    stall_count_d    = stall_count_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          hold_vertex_d = in_vertex;
          state_d       = ST_ARB;
        end
      end
      ST_ARB: begin
        if (arb_found) begin
          grant_d = arb_grant;
          state_d = ST_PUSH;
        end else if (stall_count_q != 32'hFFFF_FFFF) begin
          stall_count_d = stall_count_q + 32'd1;
        end
      end
      ST_PUSH: begin
        if (push_ok) begin
          if (dispatch_count_q != 32'hFFFF_FFFF) begin
            dispatch_count_d = dispatch_count_q + 32'd1;
          end
          rr_ptr_d = rr_after_grant;
          state_d  = ST_IDLE;
        end else begin
          // The grant lost its room, so arbitrate again with the same vertex
          state_d = ST_ARB;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards any held vertex
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      hold_vertex_q    <= '0;
      rr_ptr_q         <= '0;
      grant_q          <= '0;
      dispatch_count_q <= '0;
      stall_count_q    <= '0;
    end else begin
      state_q          <= state_d;
      hold_vertex_q    <= hold_vertex_d;
      rr_ptr_q         <= rr_ptr_d;
      grant_q          <= grant_d;
      dispatch_count_q <= dispatch_count_d;
      stall_count_q    <= stall_count_d;
    end
  end

  // Output drives
  always_comb begin
    in_ready       = (state_q == ST_IDLE) && enable;
    busy           = (state_q != ST_IDLE);
    pe_vertex      = hold_vertex_q;
    dispatch_count = dispatch_count_q;
    stall_count    = stall_count_q;
  end

endmodule
`default_nettype wire

// File: doc/pe_work_dispatcher.md
PE_WORK_DISPATCHER -- requirements
Module: pe_work_dispatcher

Interface
REQ-001 Parameter NUM_PE, default 4, number of processing elements.
REQ-002 Parameter QUEUE_DEPTH_WIDTH, default 8, width of each PE queue depth and of the threshold.
REQ-003 Parameter PE_INDEX_WIDTH, default 2, width of a PE index (log2 NUM_PE).
REQ-004 Parameter VERTEX_WIDTH, default 32, width of a frontier vertex ID.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 enable  in  1  when high, permits acceptance of new vertices.
REQ-008 in_valid  in  1  frontier vertex available.
REQ-009 in_vertex  in  VERTEX_WIDTH  frontier vertex ID.
REQ-010 in_ready  out  1  dispatcher can accept a vertex this cycle.
REQ-011 pe_queue_depths  in  NUM_PE*QUEUE_DEPTH_WIDTH  flattened depths; PE i at bits [i*QUEUE_DEPTH_WIDTH +: QUEUE_DEPTH_WIDTH].
REQ-012 dynamic_threshold  in  QUEUE_DEPTH_WIDTH  load-balance threshold from the threshold calculator.
REQ-013 pe_full  in  NUM_PE  bit i high: PE i queue cannot accept a push.
REQ-014 pe_push  out  NUM_PE  one-hot push strobe to PE queues.
REQ-015 pe_vertex  out  VERTEX_WIDTH  vertex ID accompanying pe_push.
REQ-016 busy  out  1  high whenever state is not IDLE.
REQ-017 dispatch_count  out  32  total vertices pushed.
REQ-018 stall_count  out  32  ARB cycles with no eligible PE.

Function
REQ-019 States IDLE, ARB, PUSH; one-entry holding register hold_vertex; round-robin pointer rr_ptr (PE_INDEX_WIDTH bits).
REQ-020 in_ready = (state==IDLE) && enable, combinational; no other state asserts it.
REQ-021 IDLE: in_valid && in_ready -> capture in_vertex into hold_vertex, next state ARB; otherwise stay.
REQ-022 ARB: preferred[i] = !pe_full[i] && (depth[i] <= dynamic_threshold), unsigned compare.
REQ-023 ARB: if any preferred bit set, candidates = preferred; else candidates = !pe_full (fallback).
REQ-024 ARB: grant = first candidate index searching rr_ptr, rr_ptr+1, ... wrapping modulo NUM_PE; register grant, next state PUSH.
REQ-025 ARB with no candidate (all pe_full): stay in ARB, stall_count increments by 1 that cycle.
REQ-026 PUSH: if pe_full[grant] low, pe_push = one-hot(grant) for exactly this cycle, pe_vertex = hold_vertex, dispatch_count += 1, rr_ptr <= (grant+1) mod NUM_PE, next state IDLE.
REQ-027 PUSH with pe_full[grant] high: pe_push stays 0, no count or rr_ptr change, return to ARB.
REQ-028 pe_push is 0 in IDLE and ARB; pe_vertex holds hold_vertex at all times.
REQ-029 Minimum latency: vertex accepted at edge N, pe_push high in cycle N+2; peak throughput one vertex per 3 cycles.
REQ-030 enable low does not abort a held vertex; ARB/PUSH complete normally, then IDLE with in_ready low.
REQ-031 Both counters saturate at 32'hFFFFFFFF.
REQ-032 pe_queue_depths, dynamic_threshold, pe_full sampled only in the cycle they are used; no internal copies.

Reset
REQ-033 rst high, at any time including mid-ARB/PUSH: state IDLE, hold_vertex 0, rr_ptr 0, grant 0, dispatch_count 0, stall_count 0, pe_push 0, busy 0, in_ready = enable; a held vertex is discarded.
REQ-034 First accept is permitted on the first rising edge after rst deasserts.

Verification
REQ-035 Depths {PE3..PE0} = {9,2,7,1}, threshold 4, pe_full 0, send vertex 0xA -> pe_push 4'b0001 at N+2, pe_vertex 0xA, rr_ptr 1, dispatch_count 1.
REQ-036 Same depths, second vertex 0xB -> pe_push 4'b0100 (PE2 depth 2 preferred, search from 1), rr_ptr 3.
REQ-037 All depths 10, threshold 4, pe_full 4'b0011, rr_ptr 0 -> fallback grants PE2, pe_push 4'b0100.
REQ-038 pe_full 4'b1111 for 5 cycles after accept, then 4'b1110 -> stall_count 5, then pe_push 4'b0001 two cycles after release.
REQ-039 Assert pe_full[grant] during PUSH -> no push, back to ARB, dispatch_count unchanged; re-grant to next eligible PE.
REQ-040 rst pulsed while in PUSH with vertex 0x55 -> pe_push 0 immediately, counters 0, busy 0; vertex 0x55 never delivered.
